// File: rtl/parity_unpack.sv
// Receiver for 9-bit parity-tagged symbols: rebuilds 32-bit words (MSB first), flags parity and framing errors.
// Optional saturating error counter on err_cnt when PARITY_UNPACK_ERRCNT_EN is defined.
module parity_unpack #(
  parameter bit PAR_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [8:0]  S,
  input  logic        val,
  input  logic        done,
  output logic [31:0] word,
  output logic        word_val,
  output logic [3:0]  par_err,
  output logic        any_err,
  output logic        frame_err,
  output logic [1:0]  estado
`ifdef PARITY_UNPACK_ERRCNT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GOT1 = 2'b01,
    GOT2 = 2'b10,
    GOT3 = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] part_q, part_d;
  logic [2:0]  part_err_q, part_err_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  par_err_q, par_err_d;
  logic        any_err_q, any_err_d;
  logic        word_val_q, word_val_d;
  logic        frame_err_q, frame_err_d;
  logic        sym_err;
  logic [3:0]  full_err;

  assign sym_err  = S[8] ^ (^S[7:0]) ^ PAR_ODD;
  assign full_err = {part_err_q, sym_err};

  // Handshake: a symbol is consumed on every rising edge where val=1; done only matters alongside val.
  always_comb begin
    state_d     = state_q;
    part_d      = part_q;
    part_err_d  = part_err_q;
    word_d      = word_q;
    par_err_d   = par_err_q;
    any_err_d   = any_err_q;
    word_val_d  = 1'b0;
    frame_err_d = 1'b0;
    if (val) begin
      case (state_q)
        IDLE: begin part_d[23:16] = S[7:0]; part_err_d[2] = sym_err; end
        GOT1: begin part_d[15:8]  = S[7:0]; part_err_d[1] = sym_err; end
        GOT2: begin part_d[7:0]   = S[7:0]; part_err_d[0] = sym_err; end
        default: ;
      endcase
      if (state_q == GOT3) begin
        if (done) begin
          word_d     = {part_q, S[7:0]};
          par_err_d  = full_err;
          any_err_d  = |full_err;
          word_val_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        state_d    = IDLE;
        part_d     = '0;
        part_err_d = '0;
      end else if (done) begin
        // Early terminator: the partial word is dropped, held outputs stay untouched.
        frame_err_d = 1'b1;
        state_d     = IDLE;
        part_d      = '0;
        part_err_d  = '0;
      end else begin
        state_d = state_t'(state_q + 2'd1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      part_q      <= '0;
      part_err_q  <= '0;
      word_q      <= '0;
      par_err_q   <= '0;
      any_err_q   <= 1'b0;
      word_val_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      part_q      <= part_d;
      part_err_q  <= part_err_d;
      word_q      <= word_d;
      par_err_q   <= par_err_d;
      any_err_q   <= any_err_d;
      word_val_q  <= word_val_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign word      = word_q;
  assign word_val  = word_val_q;
  assign par_err   = par_err_q;
  assign any_err   = any_err_q;
  assign frame_err = frame_err_q;
  assign estado    = state_q;

`ifdef PARITY_UNPACK_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (((word_val_d && any_err_d) || frame_err_d) && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= '0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_parity_unpack.sv
// Directed bench for parity_unpack: even-parity DUT plus an odd-parity instance sharing the same stream.
module tb_parity_unpack;

  logic        clk = 1'b0;
  logic        rst;
  logic [8:0]  S;
  logic        val;
  logic        done;
  logic [31:0] word, word_o;
  logic        word_val, word_val_o;
  logic [3:0]  par_err, par_err_o;
  logic        any_err, any_err_o;
  logic        frame_err, frame_err_o;
  logic [1:0]  estado, estado_o;
`ifdef PARITY_UNPACK_ERRCNT_EN
  logic [15:0] err_cnt, err_cnt_o;
`endif

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int wv_cnt = 0;
  int fe_cnt = 0;
  int wv_stamp_q[$];
  logic [31:0] wv_word_q[$];

  always #5 clk = ~clk;

  parity_unpack #(.PAR_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .S(S), .val(val), .done(done),
    .word(word), .word_val(word_val), .par_err(par_err), .any_err(any_err),
    .frame_err(frame_err), .estado(estado)
`ifdef PARITY_UNPACK_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );

  parity_unpack #(.PAR_ODD(1'b1)) dut_odd (
    .clk(clk), .rst(rst), .S(S), .val(val), .done(done),
    .word(word_o), .word_val(word_val_o), .par_err(par_err_o), .any_err(any_err_o),
    .frame_err(frame_err_o), .estado(estado_o)
`ifdef PARITY_UNPACK_ERRCNT_EN
    , .err_cnt(err_cnt_o)
`endif
  );

  // Pulse monitor, sampled just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    if (word_val === 1'b1) begin
      wv_cnt++;
      wv_stamp_q.push_back(cyc);
      wv_word_q.push_back(word);
    end
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic sym(input logic [8:0] s, input logic d);
    @(negedge clk);
    S = s; val = 1'b1; done = d;
  endtask

  task automatic idle(input int n, input logic d = 1'b0);
    repeat (n) begin
      @(negedge clk);
      val = 1'b0; done = d; S = 9'h1FF;
    end
  endtask

  task automatic send_clean();
    sym(9'h012, 0); sym(9'h134, 0); sym(9'h056, 0); sym(9'h078, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; val = 1'b0; done = 1'b0; S = '0;
    repeat (2) @(negedge clk);
    total++; if (word !== 32'h0) $display("FAIL reset_word got %h exp %h", word, 32'h0); else passed++;
    total++; if ({word_val, frame_err, any_err, par_err} !== 7'h0)
      $display("FAIL reset_flags got %b exp %b", {word_val, frame_err, any_err, par_err}, 7'h0); else passed++;
    total++; if (estado !== 2'b00) $display("FAIL reset_estado got %b exp %b", estado, 2'b00); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_clean();
    send_clean(); idle(1);
    total++; if (word_val !== 1'b1) $display("FAIL clean_word_val got %b exp 1", word_val); else passed++;
    total++; if (word !== 32'h12345678) $display("FAIL clean_word got %h exp %h", word, 32'h12345678); else passed++;
    total++; if ({par_err, any_err, frame_err} !== 6'b000000)
      $display("FAIL clean_errs got %b exp %b", {par_err, any_err, frame_err}, 6'b0); else passed++;
    total++; if (par_err_o !== 4'b1111 || any_err_o !== 1'b1)
      $display("FAIL odd_par_err got %b/%b exp 1111/1", par_err_o, any_err_o); else passed++;
    total++; if (word_o !== 32'h12345678) $display("FAIL odd_word got %h exp %h", word_o, 32'h12345678); else passed++;
    idle(1);
    total++; if (word_val !== 1'b0 || word !== 32'h12345678)
      $display("FAIL clean_hold got val=%b word=%h exp 0/%h", word_val, word, 32'h12345678); else passed++;
  endtask

  task automatic test_parity_fault();
    sym(9'h012, 0); sym(9'h034, 0); sym(9'h056, 0); sym(9'h078, 1); idle(1);
    total++; if (word !== 32'h12345678) $display("FAIL fault_word got %h exp %h", word, 32'h12345678); else passed++;
    total++; if (par_err !== 4'b0100) $display("FAIL fault_par_err got %b exp %b", par_err, 4'b0100); else passed++;
    total++; if (any_err !== 1'b1 || word_val !== 1'b1)
      $display("FAIL fault_any_err got %b/%b exp 1/1", any_err, word_val); else passed++;
  endtask

  task automatic test_gaps();
    int wv0;
    wv0 = wv_cnt;
    sym(9'h1AB, 0); idle(3, 1'b1);
    total++; if (estado !== 2'b01) $display("FAIL gap_estado got %b exp %b", estado, 2'b01); else passed++;
    sym(9'h1CD, 0); idle(3, 1'b1);
    sym(9'h1EF, 0); idle(3, 1'b1);
    sym(9'h101, 1); idle(1);
    total++; if (word !== 32'hABCDEF01) $display("FAIL gap_word got %h exp %h", word, 32'hABCDEF01); else passed++;
    total++; if (par_err !== 4'b0000 || any_err !== 1'b0)
      $display("FAIL gap_errs got %b/%b exp 0000/0", par_err, any_err); else passed++;
    total++; if (wv_cnt - wv0 !== 1) $display("FAIL gap_pulses got %0d exp 1", wv_cnt - wv0); else passed++;
  endtask

  task automatic test_back_to_back();
    int wv0, t0, t1;
    logic [31:0] w0, w1;
    wv0 = wv_cnt;
    wv_stamp_q.delete(); wv_word_q.delete();
    send_clean();
    sym(9'h1AB, 0); sym(9'h1CD, 0); sym(9'h1EF, 0); sym(9'h101, 1);
    idle(2);
    total++;
    if (wv_cnt - wv0 !== 2 || wv_stamp_q.size() != 2) begin
      $display("FAIL b2b_pulses got %0d exp 2", wv_cnt - wv0);
    end else begin
      passed++;
      t0 = wv_stamp_q.pop_front(); t1 = wv_stamp_q.pop_front();
      w0 = wv_word_q.pop_front();  w1 = wv_word_q.pop_front();
      total++; if (t1 - t0 !== 4) $display("FAIL b2b_spacing got %0d exp 4", t1 - t0); else passed++;
      total++; if (w0 !== 32'h12345678 || w1 !== 32'hABCDEF01)
        $display("FAIL b2b_words got %h,%h exp %h,%h", w0, w1, 32'h12345678, 32'hABCDEF01); else passed++;
    end
  endtask

  task automatic test_framing();
    int wv0, fe0;
    wv0 = wv_cnt; fe0 = fe_cnt;
    sym(9'h012, 0); sym(9'h134, 1); idle(1);
    total++; if (frame_err !== 1'b1 || word_val !== 1'b0)
      $display("FAIL early_done got fe=%b wv=%b exp 1/0", frame_err, word_val); else passed++;
    total++; if (word !== 32'hABCDEF01 || estado !== 2'b00)
      $display("FAIL early_hold got %h/%b exp %h/00", word, estado, 32'hABCDEF01); else passed++;
    sym(9'h012, 0); sym(9'h134, 0); sym(9'h056, 0); sym(9'h078, 0); idle(1);
    total++; if (frame_err !== 1'b1 || word_val !== 1'b0 || estado !== 2'b00)
      $display("FAIL no_done got fe=%b wv=%b st=%b exp 1/0/00", frame_err, word_val, estado); else passed++;
    send_clean(); idle(1);
    total++; if (word_val !== 1'b1 || word !== 32'h12345678 || frame_err !== 1'b0)
      $display("FAIL after_frame got wv=%b word=%h fe=%b exp 1/%h/0", word_val, word, frame_err, 32'h12345678); else passed++;
    total++; if (wv_cnt - wv0 !== 1 || fe_cnt - fe0 !== 2)
      $display("FAIL frame_pulses got wv=%0d fe=%0d exp 1/2", wv_cnt - wv0, fe_cnt - fe0); else passed++;
  endtask

  task automatic test_reset_mid();
    int wv0, fe0;
    wv0 = wv_cnt; fe0 = fe_cnt;
    sym(9'h1AB, 0); sym(9'h1CD, 0);
    @(negedge clk);
    rst = 1'b1; S = 9'h012; val = 1'b1; done = 1'b1;
    @(negedge clk);
    rst = 1'b0; val = 1'b0; done = 1'b0;
    total++; if (estado !== 2'b00 || word !== 32'h0)
      $display("FAIL rst_mid_state got %b/%h exp 00/%h", estado, word, 32'h0); else passed++;
    total++; if ({word_val, frame_err, any_err, par_err} !== 7'h0)
      $display("FAIL rst_mid_flags got %b exp %b", {word_val, frame_err, any_err, par_err}, 7'h0); else passed++;
    send_clean(); idle(1);
    total++; if (word_val !== 1'b1 || word !== 32'h12345678)
      $display("FAIL rst_mid_next got %b/%h exp 1/%h", word_val, word, 32'h12345678); else passed++;
    total++; if (fe_cnt - fe0 !== 0 || wv_cnt - wv0 !== 1)
      $display("FAIL rst_mid_pulses got fe=%0d wv=%0d exp 0/1", fe_cnt - fe0, wv_cnt - wv0); else passed++;
  endtask

`ifdef PARITY_UNPACK_ERRCNT_EN
  task automatic test_err_cnt();
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    repeat (3) begin
      sym(9'h012, 0); sym(9'h034, 0); sym(9'h056, 0); sym(9'h078, 1);
    end
    sym(9'h012, 1); idle(1);
    total++; if (err_cnt !== 16'd4) $display("FAIL err_cnt got %0d exp 4", err_cnt); else passed++;
    force dut.err_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.err_cnt_q;
    repeat (3) sym(9'h012, 1);
    idle(1);
    total++; if (err_cnt !== 16'hFFFF) $display("FAIL err_cnt_sat got %h exp %h", err_cnt, 16'hFFFF); else passed++;
  endtask
`endif

  initial begin
    rst = 1'b1; val = 1'b0; done = 1'b0; S = '0;
    test_reset();
    test_clean();
    test_parity_fault();
    test_gaps();
    test_back_to_back();
    test_framing();
    test_reset_mid();
`ifdef PARITY_UNPACK_ERRCNT_EN
    test_err_cnt();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
